serial_adder16: RTL and testbench
=================================

# serial_adder16

Bit-serial two's-complement adder/subtractor. It consumes the gate-level XOR primitive through a full-adder cell and sums two WIDTH-bit operands one bit per clock, LSB first. The block gives the hardware platform a low-area arithmetic stage ahead of the ALU, with a start/busy/done handshake and registered result flags.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when the block is not busy
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- in_a  in  WIDTH  operand A; sampled with start
- in_b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse: result valid
- out  out  WIDTH  result; holds until the next accepted start completes
- carry  out  1  unsigned carry-out; in sub mode, 1 = no borrow (a ≥ b unsigned)
- overflow  out  1  signed overflow
- zero  out  1  out == 0

## Operation
- States: IDLE, SHIFT, DONE. Reset puts the block in IDLE.
- Reset values: busy=0, done=0, out=0, carry=0, overflow=0, zero=1. Internal operand registers, bit counter and carry flop all clear to 0.
- Accept rule: a start is accepted only in IDLE or DONE (start=1 at a clock edge).
- On accept, at that edge:
  - load A into the A shift register;
  - load B into the B shift register, inverted when sub=1;
  - carry flop ← sub;
  - counter ← 0;
  - go to SHIFT.
- SHIFT, each edge:
  - full_adder(A[0], B[0], carry flop) → sum bit shifted into the result register at the MSB end;
  - carry flop ← cout;
  - A and B shift right by one;
  - counter +1.
- On the MSB step (counter = WIDTH−1):
  - overflow ← carry-in to MSB XOR carry-out of MSB;
  - carry ← carry-out;
  - zero ← (final shifted result == 0);
  - out ← final result;
  - go to DONE.
- DONE lasts exactly one cycle (done=1), then returns to IDLE unless a new start is accepted in it. A start accepted in DONE moves directly to SHIFT.
- start, sub, in_a and in_b are ignored in SHIFT. They are not queued.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1.
- rst_n low at any point, including mid-SHIFT, aborts the operation immediately and restores the reset values. No done pulse is produced for the aborted operation.

## Timing
- Let E0 be the edge at which start is accepted.
- busy is high from E0 through E_WIDTH; it drops at edge E_WIDTH.
- out, carry, overflow, zero and done all update at edge E_WIDTH. Latency is WIDTH cycles from acceptance to result.
- done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1.
- Back-to-back operations: holding start high in DONE gives a throughput of one result every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset deassertion is synchronised externally; the block itself needs no reset-release synchroniser.

## Structure
- The shared package holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - DATA_WIDTH=16, used as the WIDTH default.
- Sub-module full_adder (inputs in_a, in_b, in_c; outputs sum, cout) is built from two Xor, two And and one Or gate. It is instantiated once and reused each cycle.
- The counter is $clog2(WIDTH) bits wide.

## Test plan
- add 0x0001 + 0x0001 → after 16 cycles: done pulse, out=0x0002, carry=0, overflow=0, zero=0; busy high for exactly 16 cycles.
- add 0xFFFF + 0x0001 → out=0x0000, carry=1, zero=1, overflow=0.
- add 0x7FFF + 0x0001 → out=0x8000, overflow=1, carry=0.
- sub 0x0005 − 0x0007 → out=0xFFFE, carry=0 (borrow), overflow=0; then sub 0x8000 − 0x0001 → out=0x7FFF, overflow=1, carry=1.
- start pulsed with in_a=0x1234 at cycle 5 of a running 0x0003+0x0004 → ignored; out=0x0007. start held high in the DONE cycle → the next operation begins with no IDLE cycle.
- rst_n pulsed low at cycle 8 of an operation → immediately busy=0, done=0, out=0, zero=1. No done pulse follows. A subsequent 0x0002+0x0003 gives 0x0005.

Source files
------------

// File: rtl/serial_adder16_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder16_pkg
// Shared types and constants for the bit-serial adder/subtractor.
//   DATA_WIDTH : default operand/result width
//   state_t    : control state encoding (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package serial_adder16_pkg;

  localparam int unsigned DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_adder16_pkg

// File: rtl/serial_adder16_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder built from gate primitives (2x xor, 2x and, 1x or).
// Ports:
//   in_a, in_b : operand bits
//   in_c       : carry in
//   sum        : in_a ^ in_b ^ in_c
//   cout       : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic in_a,
  input  logic in_b,
  input  logic in_c,
  output wire  sum,
  output wire  cout
);

  wire w_p;  // propagate
  wire w_g;  // generate
  wire w_t;  // propagated carry

  xor u_xor_p (w_p, in_a, in_b);
  xor u_xor_s (sum, w_p, in_c);
  and u_and_g (w_g, in_a, in_b);
  and u_and_t (w_t, w_p, in_c);
  or  u_or_c  (cout, w_g, w_t);

endmodule : full_adder

// File: rtl/serial_adder16.sv
// -----------------------------------------------------------------------------
// serial_adder16
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// A single full_adder cell is reused every cycle; the carry lives in a flop.
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   start            : request, accepted only in IDLE or DONE
//   sub              : 0 = a+b, 1 = a-b (sampled with start)
//   in_a, in_b       : operands (sampled with start)
//   busy             : high while bits are being processed
//   done             : one-cycle result-valid pulse
//   out              : result, held until the next operation completes
//   carry            : unsigned carry-out (sub: 1 = no borrow)
//   overflow         : signed overflow
//   zero             : out == 0
// -----------------------------------------------------------------------------
module serial_adder16
  import serial_adder16_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;        // operand A, shifted right each step
  logic [WIDTH-1:0]   r_b;        // operand B (pre-inverted for sub)
  logic [WIDTH-2:0]   r_acc;      // sum bits collected so far, MSB-aligned
  logic               r_cin;      // carry into the current bit
  logic [CNT_W-1:0]   r_cnt;      // index of the bit being processed
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_out;
  logic               r_carry;
  logic               r_overflow;
  logic               r_zero;

  wire                w_sum;
  wire                w_cout;
  logic [WIDTH-1:0]   w_res;
  logic               w_last;

  // Shared full-adder cell: current LSBs plus the carry flop.
  full_adder u_fa (
    .in_a (r_a[0]),
    .in_b (r_b[0]),
    .in_c (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // New sum bit enters at the MSB; after WIDTH steps this is the full result.
  assign w_res  = {w_sum, r_acc};
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Control FSM, datapath shift registers and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cin      <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            r_a     <= in_a;
            r_b     <= sub ? ~in_b : in_b;
            r_cin   <= sub;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end

        SHIFT: begin
          r_acc <= w_res[WIDTH-1:1];
          r_cin <= w_cout;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // r_cin is the carry into the MSB here, w_cout the carry out.
            r_overflow <= r_cin ^ w_cout;
            r_carry    <= w_cout;
            r_zero     <= (w_res == '0);
            r_out      <= w_res;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out      = r_out;
  assign carry    = r_carry;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule : serial_adder16

// File: tb/tb_serial_adder16.sv
// -----------------------------------------------------------------------------
// tb_serial_adder16
// Self-checking bench: an arithmetic reference model predicts every output on
// every cycle; directed operations pin the model to hand-computed results.
// -----------------------------------------------------------------------------
module tb_serial_adder16;

  localparam int unsigned W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] in_a  = '0;
  logic [W-1:0] in_b  = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         carry;
  logic         overflow;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_adder16 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] f_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    return s ? W'(a - b) : W'(a + b);
  endfunction

  function automatic logic f_carry(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
    logic [W:0] t;
    if (s) return (a >= b);
    t = {1'b0, a} + {1'b0, b};
    return t[W];
  endfunction

  function automatic logic f_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? (sa - sb) : (sa + sb);
    return (r > 32767) || (r < -32768);
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle-level behavioural model: an accepted op completes WIDTH edges later.
  // ---------------------------------------------------------------------------
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_out   = '0;
  logic         m_carry = 1'b0;
  logic         m_ovf   = 1'b0;
  logic         m_zero  = 1'b1;
  int           m_left  = 0;
  logic [W-1:0] p_out   = '0;
  logic         p_carry = 1'b0;
  logic         p_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_out   <= '0;
      m_carry <= 1'b0;
      m_ovf   <= 1'b0;
      m_zero  <= 1'b1;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_done  <= 1'b1;
          m_out   <= p_out;
          m_carry <= p_carry;
          m_ovf   <= p_ovf;
          m_zero  <= (p_out == '0);
        end
      end else if (start) begin
        p_out   <= f_res(in_a, in_b, sub);
        p_carry <= f_carry(in_a, in_b, sub);
        p_ovf   <= f_ovf(in_a, in_b, sub);
        m_busy  <= 1'b1;
        m_left  <= W;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",     32'(busy),     32'(m_busy));
      chk("cyc_done",     32'(done),     32'(m_done));
      chk("cyc_out",      32'(out),      32'(m_out));
      chk("cyc_carry",    32'(carry),    32'(m_carry));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_zero",     32'(zero),     32'(m_zero));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input int inj, input int rst_at,
                       output int busy_cyc, output bit got);
    bit from_done;
    from_done = done;
    in_a  = a;
    in_b  = b;
    sub   = s;
    start = 1'b1;
    step();
    start = 1'b0;
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    sub   = 1'($urandom);
    if (from_done) chk("b2b_no_idle_busy", 32'(busy), 32'd1);
    busy_cyc = 0;
    got      = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (rst_at >= 0 && busy_cyc == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(done), 32'd0);
          chk("abort_out",  32'(out),  32'd0);
          chk("abort_zero", 32'(zero), 32'd1);
          step();
          rst_n = 1'b1;
          return;
        end
        start = (busy_cyc == inj);
        if (start) in_a = 16'h1234;
        step();
        start = 1'b0;
      end
    end
  endtask

  task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] eo, input logic ec, input logic ev,
                     input logic ez, input string nm, input int inj);
    int bc;
    bit got;
    do_op(a, b, s, inj, -1, bc, got);
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_out"},      32'(out),      32'(eo));
      chk({nm, "_carry"},    32'(carry),    32'(ec));
      chk({nm, "_overflow"}, 32'(overflow), 32'(ev));
      chk({nm, "_zero"},     32'(zero),     32'(ez));
      chk({nm, "_model"},    32'(m_out),    32'(eo));
      chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int bc;
    bit got;
    int ndone;

    repeat (3) step();
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_out",      32'(out),      32'd0);
    chk("rst_carry",    32'(carry),    32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_zero",     32'(zero),     32'd1);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    dir(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, "add_1_1", -1);
    repeat (2) step();
    dir(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_ffff_1", -1);
    dir(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_7fff_1", -1);
    dir(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_5_7", -1);
    dir(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_8000_1", -1);
    repeat (1) step();
    dir(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, "ignore_mid_start", 5);
    repeat (2) step();

    // Abort mid-operation, then make sure no stale done pulse appears.
    do_op(16'h1111, 16'h2222, 1'b0, -1, 8, bc, got);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      step();
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    dir(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, "add_after_abort", -1);

    // Randomized operations with random gaps (0 gives back-to-back from DONE).
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1, -1, bc, got);
      chk("rand_done_seen", 32'(got), 32'd1);
    end

    repeat (3) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_adder16
